// File: rtl/i2c_pkg.sv
// Shared state encoding and register index constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_MSB,
    ST_WR_MSB_ACK,
    ST_WR_LSB,
    ST_WR_LSB_ACK,
    ST_RD_BYTE,
    ST_RD_ACK
  } state_t;

  localparam logic [1:0] REG_VALUE0 = 2'd0;
  localparam logic [1:0] REG_1      = 2'd1;
  localparam logic [1:0] REG_2      = 2'd2;
  localparam logic [1:0] REG_3      = 2'd3;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into clk and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Reset to 1 so an idle bus produces no spurious edges when reset lifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync[0] <= i_scl;
      r_sda_sync[0] <= i_sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_scl_sync[i] <= r_scl_sync[i-1];
        r_sda_sync[i] <= r_sda_sync[i-1];
      end
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl & r_scl_d;
  assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing one read-only word and three read/write 16-bit registers
// behind a 2-bit pointer; words are transferred MSB byte first.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  input  logic        sdaIn,
  output logic        sdaDriveLow,
  input  logic [15:0] value0,
  output logic [15:0] reg1,
  output logic [15:0] reg2,
  output logic [15:0] reg3,
  output logic        wrStrobe,
  output logic [1:0]  wrPtr,
  output logic        busy
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_scl      (scl),
    .i_sda      (sdaIn),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_stage, w_stage_nxt;
  logic [1:0]  r_ptr, w_ptr_nxt;
  logic [15:0] r_rd_word, w_rd_word_nxt;
  logic        r_rd_lsb, w_rd_lsb_nxt;
  logic        r_rw, w_rw_nxt;
  logic        r_sda_low, w_sda_low_nxt;
  logic        r_busy, w_busy_nxt;
  logic [15:0] r_reg1, r_reg2, r_reg3, w_reg1_nxt, w_reg2_nxt, w_reg3_nxt;
  logic        r_wr_strobe, w_wr_strobe_nxt;
  logic [1:0]  r_wr_ptr, w_wr_ptr_nxt;
  logic [15:0] w_sel_word;
  logic [7:0]  w_tx_byte;
  logic [2:0]  w_bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_stage     <= '0;
      r_ptr       <= REG_VALUE0;
      r_rd_word   <= '0;
      r_rd_lsb    <= 1'b0;
      r_rw        <= 1'b0;
      r_sda_low   <= 1'b0;
      r_busy      <= 1'b0;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_reg3      <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_stage     <= w_stage_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rd_word   <= w_rd_word_nxt;
      r_rd_lsb    <= w_rd_lsb_nxt;
      r_rw        <= w_rw_nxt;
      r_sda_low   <= w_sda_low_nxt;
      r_busy      <= w_busy_nxt;
      r_reg1      <= w_reg1_nxt;
      r_reg2      <= w_reg2_nxt;
      r_reg3      <= w_reg3_nxt;
      r_wr_strobe <= w_wr_strobe_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
    end
  end

  always_comb begin
    case (r_ptr)
      REG_1:   w_sel_word = r_reg1;
      REG_2:   w_sel_word = r_reg2;
      REG_3:   w_sel_word = r_reg3;
      default: w_sel_word = value0;
    endcase
  end

  assign w_tx_byte = r_rd_lsb ? r_rd_word[7:0] : r_rd_word[15:8];
  assign w_bit_idx = 3'd7 - r_bit_cnt[2:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_stage_nxt     = r_stage;
    w_ptr_nxt       = r_ptr;
    w_rd_word_nxt   = r_rd_word;
    w_rd_lsb_nxt    = r_rd_lsb;
    w_rw_nxt        = r_rw;
    w_sda_low_nxt   = r_sda_low;
    w_busy_nxt      = r_busy;
    w_reg1_nxt      = r_reg1;
    w_reg2_nxt      = r_reg2;
    w_reg3_nxt      = r_reg3;
    w_wr_strobe_nxt = 1'b0;
    w_wr_ptr_nxt    = r_wr_ptr;

    if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_bit_cnt_nxt = '0;
      w_sda_low_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = ST_ADDR;
      w_bit_cnt_nxt = '0;
      w_sda_low_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WR_MSB, ST_WR_LSB: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_shift_nxt   = {r_shift[6:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_bit_cnt_nxt = '0;
            case (r_state)
              ST_ADDR: begin
                if (r_shift[7:1] == ADDRESS) begin
                  w_state_nxt   = ST_ADDR_ACK;
                  w_rw_nxt      = r_shift[0];
                  w_busy_nxt    = 1'b1;
                  w_sda_low_nxt = 1'b1;
                end else begin
                  w_state_nxt = ST_IDLE;
                end
              end
              ST_PTR: begin
                w_ptr_nxt     = r_shift[1:0];
                w_state_nxt   = ST_PTR_ACK;
                w_sda_low_nxt = 1'b1;
              end
              ST_WR_MSB: begin
                w_stage_nxt   = r_shift;
                w_state_nxt   = ST_WR_MSB_ACK;
                w_sda_low_nxt = 1'b1;
              end
              default: begin
                w_state_nxt   = ST_WR_LSB_ACK;
                w_sda_low_nxt = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_state_nxt   = ST_RD_BYTE;
              w_rd_word_nxt = w_sel_word;
              w_rd_lsb_nxt  = 1'b0;
              w_sda_low_nxt = ~w_sel_word[15];
              w_bit_cnt_nxt = 4'd1;
            end else begin
              w_state_nxt   = ST_PTR;
              w_sda_low_nxt = 1'b0;
            end
          end
        end
        ST_PTR_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt   = ST_WR_MSB;
            w_sda_low_nxt = 1'b0;
          end
        end
        ST_WR_MSB_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt   = ST_WR_LSB;
            w_sda_low_nxt = 1'b0;
          end
        end
        ST_WR_LSB_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt     = ST_WR_MSB;
            w_sda_low_nxt   = 1'b0;
            w_wr_strobe_nxt = 1'b1;
            w_wr_ptr_nxt    = r_ptr;
            // Pointer 0 targets the read-only word: acknowledged, strobed, not stored.
            case (r_ptr)
              REG_1:   w_reg1_nxt = {r_stage, r_shift};
              REG_2:   w_reg2_nxt = {r_stage, r_shift};
              REG_3:   w_reg3_nxt = {r_stage, r_shift};
              default: ;
            endcase
          end
        end
        ST_RD_BYTE: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_state_nxt   = ST_RD_ACK;
              w_sda_low_nxt = 1'b0;
              w_bit_cnt_nxt = '0;
            end else begin
              w_sda_low_nxt = ~w_tx_byte[w_bit_idx];
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise && w_sda) begin
            w_state_nxt = ST_IDLE;
          end else if (w_scl_fall) begin
            w_state_nxt   = ST_RD_BYTE;
            w_bit_cnt_nxt = 4'd1;
            if (r_rd_lsb) begin
              w_rd_word_nxt = w_sel_word;
              w_rd_lsb_nxt  = 1'b0;
              w_sda_low_nxt = ~w_sel_word[15];
            end else begin
              w_rd_lsb_nxt  = 1'b1;
              w_sda_low_nxt = ~r_rd_word[7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sdaDriveLow = r_sda_low;
  assign reg1        = r_reg1;
  assign reg2        = r_reg2;
  assign reg3        = r_reg3;
  assign wrStrobe    = r_wr_strobe;
  assign wrPtr       = r_wr_ptr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bus-master bench for i2c_target_regs.
module tb_i2c_target_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] value0 = 16'h0000;
  logic        sda_drive;
  logic [15:0] reg1, reg2, reg3;
  logic        wr_strobe;
  logic [1:0]  wr_ptr;
  logic        busy;
  wire         sda_bus = sda_m & ~sda_drive;

  i2c_target_regs #(.ADDRESS(7'h48), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl         (scl_m),
    .sdaIn       (sda_bus),
    .sdaDriveLow (sda_drive),
    .value0      (value0),
    .reg1        (reg1),
    .reg2        (reg2),
    .reg3        (reg3),
    .wrStrobe    (wr_strobe),
    .wrPtr       (wr_ptr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_strobe = 0;
  int n_drive = 0;
  int n_busy = 0;
  logic [1:0]  log_ptr [$];
  logic [15:0] log_val [$];

  always @(negedge clk) begin
    if (sda_drive) n_drive++;
    if (busy) n_busy++;
    if (wr_strobe) begin
      n_strobe++;
      log_ptr.push_back(wr_ptr);
      case (wr_ptr)
        2'd1: log_val.push_back(reg1);
        2'd2: log_val.push_back(reg2);
        2'd3: log_val.push_back(reg3);
        default: log_val.push_back(16'h0000);
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wt();
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wt();
    sda_m = 1'b0; wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wt();
    scl_m = 1'b1; wt();
    sda_m = 1'b0; wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wt();
    scl_m = 1'b1; wt();
    sda_m = 1'b1; wt();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wt();
      scl_m = 1'b1; wt(); wt();
      scl_m = 1'b0; wt();
    end
    sda_m = 1'b1; wt();
    scl_m = 1'b1; wt();
    ack = ~sda_bus; wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    wr_byte(b, a);
    chk(tag, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic rd_byte(output logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      wt();
      scl_m = 1'b1; wt();
      b[i] = sda_bus; wt();
      scl_m = 1'b0;
    end
    wt();
    sda_m = nack; wt();
    scl_m = 1'b1; wt(); wt();
    scl_m = 1'b0; wt();
    sda_m = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp, input logic nack);
    logic [7:0] b;
    rd_byte(b, nack);
    chk(tag, {24'd0, b}, {24'd0, exp});
  endtask

  initial begin
    int s0, d0, b0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_sda", {31'd0, sda_drive}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    chk("rst_wrptr", {30'd0, wr_ptr}, 32'd0);
    chk("rst_regs", {reg1, reg2 | reg3}, 32'd0);
    rst_n = 1'b1;
    wt();

    // Write 0x1234 to reg2
    s0 = n_strobe;
    i2c_start();
    wr_chk("w1_addr_ack", 8'h90, 1'b1);
    chk("w1_busy", {31'd0, busy}, 32'd1);
    wr_chk("w1_ptr_ack", 8'h02, 1'b1);
    wr_chk("w1_msb_ack", 8'h12, 1'b1);
    wr_chk("w1_lsb_ack", 8'h34, 1'b1);
    i2c_stop();
    chk("w1_reg2", {16'd0, reg2}, 32'h1234);
    chk("w1_nstrobe", n_strobe - s0, 32'd1);
    chk("w1_logptr", {30'd0, log_ptr[s0]}, 32'd2);
    chk("w1_busy_after_stop", {31'd0, busy}, 32'd0);
    chk("w1_other_regs", {reg1, reg3}, 32'd0);

    // Address mismatch
    s0 = n_strobe; d0 = n_drive; b0 = n_busy;
    i2c_start();
    wr_chk("mm_addr_nack", 8'h92, 1'b0);
    wr_chk("mm_data_nack", 8'h02, 1'b0);
    i2c_stop();
    chk("mm_no_drive", n_drive - d0, 32'd0);
    chk("mm_no_busy", n_busy - b0, 32'd0);
    chk("mm_reg2", {16'd0, reg2}, 32'h1234);
    chk("mm_nstrobe", n_strobe - s0, 32'd0);

    // Two consecutive words into reg3
    s0 = n_strobe;
    i2c_start();
    wr_chk("w3_addr_ack", 8'h90, 1'b1);
    wr_chk("w3_ptr_ack", 8'h03, 1'b1);
    wr_chk("w3_b0", 8'hAA, 1'b1);
    wr_chk("w3_b1", 8'hBB, 1'b1);
    chk("w3_first_commit", {16'd0, reg3}, 32'hAABB);
    wr_chk("w3_b2", 8'hCC, 1'b1);
    wr_chk("w3_b3", 8'hDD, 1'b1);
    i2c_stop();
    chk("w3_nstrobe", n_strobe - s0, 32'd2);
    chk("w3_log0", {14'd0, log_ptr[s0], log_val[s0]}, {14'd0, 2'd3, 16'hAABB});
    chk("w3_log1", {14'd0, log_ptr[s0+1], log_val[s0+1]}, {14'd0, 2'd3, 16'hCCDD});

    // STOP after MSB only discards the partial word
    s0 = n_strobe;
    i2c_start();
    wr_chk("pw_addr_ack", 8'h90, 1'b1);
    wr_chk("pw_ptr_ack", 8'h01, 1'b1);
    wr_chk("pw_msb_ack", 8'h55, 1'b1);
    i2c_stop();
    chk("pw_reg1", {16'd0, reg1}, 32'h0000);
    chk("pw_nstrobe", n_strobe - s0, 32'd0);

    // Write to pointer 0: strobed, nothing stored
    s0 = n_strobe;
    i2c_start();
    wr_chk("p0_addr_ack", 8'h90, 1'b1);
    wr_chk("p0_ptr_ack", 8'h00, 1'b1);
    wr_chk("p0_msb_ack", 8'h11, 1'b1);
    wr_chk("p0_lsb_ack", 8'h22, 1'b1);
    i2c_stop();
    chk("p0_nstrobe", n_strobe - s0, 32'd1);
    chk("p0_logptr", {30'd0, log_ptr[s0]}, 32'd0);
    chk("p0_regs12", {reg1, reg2}, {16'h0000, 16'h1234});
    chk("p0_reg3", {16'd0, reg3}, 32'hCCDD);

    // Read value0 via repeated START
    value0 = 16'hBEEF;
    i2c_start();
    wr_chk("r0_addr_ack", 8'h90, 1'b1);
    wr_chk("r0_ptr_ack", 8'h00, 1'b1);
    i2c_rstart();
    wr_chk("r0_raddr_ack", 8'h91, 1'b1);
    rd_chk("r0_msb", 8'hBE, 1'b0);
    rd_chk("r0_lsb", 8'hEF, 1'b1);
    wt();
    chk("r0_sda_released", {31'd0, sda_drive}, 32'd0);
    i2c_stop();

    // Read reg3 and wrap back to its MSB
    i2c_start();
    wr_chk("r3_addr_ack", 8'h90, 1'b1);
    wr_chk("r3_ptr_ack", 8'h03, 1'b1);
    i2c_rstart();
    wr_chk("r3_raddr_ack", 8'h91, 1'b1);
    rd_chk("r3_msb", 8'hCC, 1'b0);
    rd_chk("r3_lsb", 8'hDD, 1'b0);
    rd_chk("r3_wrap", 8'hCC, 1'b1);
    i2c_stop();

    // Reset during a read bit while SDA is held low (reg2 MSB = 0x12, bit7 = 0)
    i2c_start();
    wr_chk("rr_addr_ack", 8'h90, 1'b1);
    wr_chk("rr_ptr_ack", 8'h02, 1'b1);
    i2c_rstart();
    wr_chk("rr_raddr_ack", 8'h91, 1'b1);
    wt();
    chk("rr_driving_before", {31'd0, sda_drive}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_sda_async", {31'd0, sda_drive}, 32'd0);
    chk("rr_regs12", {reg1, reg2}, 32'd0);
    chk("rr_reg3_busy", {15'd0, busy, reg3}, 32'd0);
    wt();
    rst_n = 1'b1;
    d0 = n_drive;
    for (int i = 0; i < 3; i++) begin
      wt(); scl_m = 1'b1; wt(); scl_m = 1'b0;
    end
    wt();
    chk("rr_ignored", n_drive - d0, 32'd0);
    i2c_stop();

    // Pointer returned to 0 by reset
    value0 = 16'h5A5A;
    i2c_start();
    wr_chk("pr_raddr_ack", 8'h91, 1'b1);
    rd_chk("pr_value0", 8'h5A, 1'b1);
    i2c_stop();

    s0 = n_strobe;
    i2c_start();
    wr_chk("pr_addr_ack", 8'h90, 1'b1);
    wr_chk("pr_ptr_ack", 8'h01, 1'b1);
    wr_chk("pr_msb_ack", 8'hAB, 1'b1);
    wr_chk("pr_lsb_ack", 8'hCD, 1'b1);
    i2c_stop();
    chk("pr_reg1", {16'd0, reg1}, 32'hABCD);
    chk("pr_nstrobe", n_strobe - s0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
